aes128_encr: RTL and testbench



---
 rtl/aes_pkg.sv | 92 +++++++++
 rtl/aes_round_stage.sv | 80 ++++++++
 rtl/aes128_encr.sv | 53 +++++
 tb/tb_aes128_encr.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared types, forward S-box, xtime and Rcon table.
// Imported by the round stages and the encryption top.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  // Round constants, indexed by round number 1..10
  localparam byte_t RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t sbox(input byte_t b);
    byte_t s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
      8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
      8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
      8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
      8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
      8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
      8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
      8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
      8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
      8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
      8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
      8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
      8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
      8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
      8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
      8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
      8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
      8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
      8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
      8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
      8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
      8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
      8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
      8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
      8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
      8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
      8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
      8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
      8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
      8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
      8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
      8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
      8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/aes_round_stage.sv
// One registered AES round: SubBytes, ShiftRows, MixColumns (skipped
// when last_i), AddRoundKey, plus the matching key-schedule step.
// Ports: clk, rst, vld_i (load enable, else clear), state_i, key_i,
//        rnd_i (round 1..10), last_i, state_o / key_o (registered).
module aes_round_stage
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       vld_i,
  input  state_t     state_i,
  input  state_t     key_i,
  input  logic [3:0] rnd_i,
  input  logic       last_i,
  output state_t     state_o,
  output state_t     key_o
);

  byte_t  sb [16];
  byte_t  sr [16];
  byte_t  mc [16];
  word_t  t;
  word_t  n0, n1, n2, n3;
  state_t key_d, state_d;
  state_t key_q, state_q;

  // Byte i lives in bits [127-8i -: 8]; state[r][c] is byte 4c+r
  for (genvar i = 0; i < 16; i++) begin : g_sb
    assign sb[i] = sbox(state_i[127-8*i -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    assign mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1])
                     ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1])
                     ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2])
                     ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1]
                     ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  // Key step: SubWord(RotWord(w3)) ^ Rcon, then the word chain
  assign t = {sbox(key_i[23:16]) ^ RCON[rnd_i],
              sbox(key_i[15:8]),
              sbox(key_i[7:0]),
              sbox(key_i[31:24])};

  assign n0 = key_i[127:96] ^ t;
  assign n1 = key_i[95:64]  ^ n0;
  assign n2 = key_i[63:32]  ^ n1;
  assign n3 = key_i[31:0]   ^ n2;
  assign key_d = {n0, n1, n2, n3};

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign state_d[127-8*i -: 8] = (last_i ? sr[i] : mc[i])
                                 ^ key_d[127-8*i -: 8];
  end

  // Invalid slots are flushed to zero so no partial data moves on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      key_q   <= '0;
    end else if (vld_i) begin
      state_q <= state_d;
      key_q   <= key_d;
    end else begin
      state_q <= '0;
      key_q   <= '0;
    end
  end

  assign state_o = state_q;
  assign key_o   = key_q;

endmodule

// File: rtl/aes128_encr.sv
// Fully pipelined AES-128 encryption, one block per cycle, 11-cycle latency.
// Ports: clk, rst (async, active-high), ip_data, ip_key, encr_data_out.
module aes128_encr
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] ip_data,
  input  logic [127:0] ip_key,
  output logic [127:0] encr_data_out
);

  state_t      st0_q, key0_q;
  logic [10:0] vld_q;
  state_t      st [11];
  state_t      ky [11];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st0_q  <= '0;
      key0_q <= '0;
      vld_q  <= '0;
    end else begin
      st0_q  <= ip_data ^ ip_key;
      key0_q <= ip_key;
      vld_q  <= {vld_q[9:0], 1'b1};
    end
  end

  assign st[0] = st0_q;
  assign ky[0] = key0_q;

  // Stage i is fed by stage i-1, so it loads on vld_q[i-1]
  for (genvar i = 1; i <= 10; i++) begin : g_rnd
    aes_round_stage u_rnd (
      .clk     (clk),
      .rst     (rst),
      .vld_i   (vld_q[i-1]),
      .state_i (st[i-1]),
      .key_i   (ky[i-1]),
      .rnd_i   (4'(i)),
      .last_i  (i == 10),
      .state_o (st[i]),
      .key_o   (ky[i])
    );
  end

  assign encr_data_out = st[10];

  logic unused;
  assign unused = ^{ky[10], vld_q[10]};

endmodule

// File: tb/tb_aes128_encr.sv
// Self-checking bench for aes128_encr: FIPS vectors, back-to-back,
// random blocks against an independent model, start and mid-stream reset.
module tb_aes128_encr;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] ip_data;
  logic [127:0] ip_key;
  logic [127:0] encr_data_out;

  int n_chk  = 0;
  int n_fail = 0;
  int ne     = 0;

  logic [7:0]   sbt [256];
  logic [127:0] q [$];

  localparam logic [127:0] C1_D = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_D  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_C  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_C  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes128_encr dut (
    .clk           (clk),
    .rst           (rst),
    .ip_data       (ip_data),
    .ip_key        (ip_key),
    .encr_data_out (encr_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt,
                                           input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   k [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    for (int r = 1; r <= 10; r++) begin
      k[0] = k[0] ^ sbt[k[13]] ^ rc;
      k[1] = k[1] ^ sbt[k[14]];
      k[2] = k[2] ^ sbt[k[15]];
      k[3] = k[3] ^ sbt[k[12]];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = gmul(rc, 8'h02);
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[4*c+w] = sbt[s[4*((c+w)%4)+w]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one block, let one edge sample it, then check the output
  task automatic step(input logic [127:0] d, input logic [127:0] k);
    ip_data = d;
    ip_key  = k;
    q.push_back(aes_ref(d, k));
    @(posedge clk);
    @(negedge clk);
    ne++;
    if (ne <= 10) check("wait_zero", encr_data_out, 128'h0);
    else check("pipe", encr_data_out, q[ne-11]);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      logic [7:0] v, inv;
      v   = 8'(a);
      inv = 8'h00;
      if (v != 8'h00) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, v);
      end
      sbt[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
             ^ rotl(inv, 4) ^ 8'h63;
    end

    rst     = 1'b1;
    ip_data = rnd128();
    ip_key  = rnd128();
    repeat (3) begin
      @(negedge clk);
      check("rst_hold", encr_data_out, 128'h0);
      ip_data = rnd128();
      ip_key  = rnd128();
    end

    rst = 1'b0;
    ne  = 0;
    step(C1_D, C1_K);
    step(B_D, B_K);
    step(128'h0, 128'h0);
    repeat (7) step(rnd128(), rnd128());
    step(rnd128(), rnd128());
    check("fips_c1", encr_data_out, C1_C);
    step(rnd128(), rnd128());
    check("fips_b", encr_data_out, B_C);
    step(rnd128(), rnd128());
    check("all_zero", encr_data_out, Z_C);
    repeat (20) step(rnd128(), rnd128());

    #2 rst = 1'b1;
    #1 check("rst_async_mid", encr_data_out, 128'h0);
    @(negedge clk);
    check("rst_mid_hold", encr_data_out, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    ne = 0;
    repeat (14) step(rnd128(), rnd128());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
